// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state encoding for the UART command-frame parser.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_RD_WAIT,
    ST_SEND_ACK,
    ST_SEND_DATA,
    ST_SEND_NAK
  } state_e;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clear wins over enable, expire flags TIMEOUT-1.
module uart_cmd_timer #(
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes framed write/read commands from the RX FIFO, strobes the register
// bank and pushes ACK / NAK / read-data bytes into the TX FIFO.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_empty,
  input  logic [7:0]    r_data,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic          wr_uart,
  output logic [7:0]    w_data,
  output logic          reg_wr,
  output logic          reg_rd,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  input  logic [7:0]    reg_rdata,
  output logic          frame_err
);

  state_e        state_q, state_d;
  logic          cmd_rd_q, cmd_rd_d;
  logic [7:0]    chk_q, chk_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          frame_err_q, frame_err_d;
  logic          in_frame, tmr_en, tmr_clr, tmr_expire;

  // The timer only runs while a partial frame is waiting on an empty FIFO.
  assign in_frame = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
  assign tmr_en   = in_frame && rx_empty;
  assign tmr_clr  = rd_uart || !in_frame;

  uart_cmd_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_rd_q    <= 1'b0;
      chk_q       <= 8'h00;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_rd_q    <= cmd_rd_d;
      chk_q       <= chk_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_rd_d    = cmd_rd_q;
    chk_d       = chk_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_uart && r_data == SYNC) begin
          state_d = ST_CMD;
          chk_d   = 8'h00;
        end
      end
      ST_CMD: begin
        if (rd_uart) begin
          chk_d    = chk_q ^ r_data;
          cmd_rd_d = (r_data == CMD_RD);
          if (r_data == CMD_WR || r_data == CMD_RD) begin
            state_d = ST_ADDR;
          end else begin
            state_d     = ST_SEND_NAK;
            frame_err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (rd_uart) begin
          addr_d  = r_data[AW-1:0];
          chk_d   = chk_q ^ r_data;
          state_d = cmd_rd_q ? ST_CHK : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rd_uart) begin
          wdata_d = r_data;
          chk_d   = chk_q ^ r_data;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rd_uart) begin
          if (r_data == chk_q) begin
            state_d = ST_EXEC;
          end else begin
            state_d     = ST_SEND_NAK;
            frame_err_d = 1'b1;
          end
        end
      end
      ST_EXEC:    state_d = cmd_rd_q ? ST_RD_WAIT : ST_SEND_ACK;
      ST_RD_WAIT: begin
        rdata_d = reg_rdata;
        state_d = ST_SEND_ACK;
      end
      ST_SEND_ACK: begin
        if (wr_uart) state_d = cmd_rd_q ? ST_SEND_DATA : ST_IDLE;
      end
      ST_SEND_DATA, ST_SEND_NAK: begin
        if (wr_uart) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // tmr_en implies an empty FIFO, so a timeout never races a pop.
    if (tmr_en && tmr_expire) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    reg_wr  = 1'b0;
    reg_rd  = 1'b0;
    case (state_q)
      ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CHK: rd_uart = !rx_empty && !reset;
      ST_EXEC: begin
        reg_wr = !cmd_rd_q;
        reg_rd = cmd_rd_q;
      end
      ST_SEND_ACK: begin
        wr_uart = !tx_full && !reset;
        w_data  = ACK;
      end
      ST_SEND_DATA: begin
        wr_uart = !tx_full && !reset;
        w_data  = rdata_q;
      end
      ST_SEND_NAK: begin
        wr_uart = !tx_full && !reset;
        w_data  = NAK;
      end
      default: ;
    endcase
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench: FIFO/register-bank stand-ins around uart_cmd_parser,
// expectations generated per frame from the command-protocol rules.
module tb_uart_cmd_parser;

  localparam int AW      = 8;
  localparam int TIMEOUT = 40;
  localparam int TW      = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_empty = 1'b1;
  logic [7:0]    r_data = 8'h00;
  logic          rd_uart;
  logic          tx_full = 1'b0;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          reg_wr;
  logic          reg_rd;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata = 8'h00;
  logic          frame_err;

  uart_cmd_parser #(.AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .r_data    (r_data),
    .rd_uart   (rd_uart),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  model_mem[256];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, err_cnt = 0, exp_err_cnt = 0;
  int last_pop_cyc = 0, last_err_cyc = 0, strobe_cyc = 0, rd_phase = 0;
  bit strobe_rd = 0, first_push_pending = 0, bp_seen = 0, pop_now = 0;
  bit rand_bp = 0, force_full = 0;
  logic [7:0]  rd_addr = 8'h00;
  logic [31:0] exp_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor on the falling edge, FIFO/flag updates just after the rising edge.
  always begin
    @(negedge clk);
    cyc++;
    if (rd_uart) begin
      pop_now      = 1'b1;
      last_pop_cyc = cyc;
    end
    if (tx_full) begin
      bp_seen = 1'b1;
      check_eq("wr_while_full", wr_uart, 0);
    end
    if (wr_uart) begin
      if (first_push_pending) begin
        if (!bp_seen) check_eq("push_latency", cyc - strobe_cyc, strobe_rd ? 2 : 1);
        first_push_pending = 1'b0;
      end
      exp_v = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'h1FF;
      check_eq("tx_byte", w_data, exp_v);
    end
    if (rd_phase == 2) begin
      reg_rdata = 8'($urandom);
      rd_phase  = 0;
    end
    if (rd_phase == 1) begin
      reg_rdata = mem[rd_addr];
      rd_phase  = 2;
    end
    if (reg_wr) begin
      check_eq("wr_strobe_latency", cyc - last_pop_cyc, 1);
      exp_v = (exp_wr_q.size() > 0) ? {16'd0, exp_wr_q.pop_front()} : 32'h10000;
      check_eq("wr_addr_data", {reg_addr, reg_wdata}, exp_v);
      mem[reg_addr] = reg_wdata;
      strobe_cyc = cyc; strobe_rd = 1'b0; first_push_pending = 1'b1; bp_seen = 1'b0;
    end
    if (reg_rd) begin
      check_eq("rd_strobe_latency", cyc - last_pop_cyc, 1);
      exp_v = (exp_rd_q.size() > 0) ? {24'd0, exp_rd_q.pop_front()} : 32'h100;
      check_eq("rd_addr", reg_addr, exp_v);
      rd_addr  = reg_addr;
      rd_phase = 1;
      strobe_cyc = cyc; strobe_rd = 1'b1; first_push_pending = 1'b1; bp_seen = 1'b0;
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_now  = 1'b0;
    tx_full  = rand_bp ? ($urandom_range(0, 3) == 0) : force_full;
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  end

  task automatic push_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk);
    #2;
    rx_q.push_back(b);
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] chk_xor);
    logic [7:0] chk;
    chk = 8'h57 ^ a ^ d ^ chk_xor;
    if (chk_xor != 8'h00) begin
      exp_q.push_back(8'h15);
      exp_err_cnt++;
    end else begin
      exp_wr_q.push_back({a, d});
      exp_q.push_back(8'h06);
      model_mem[a] = d;
    end
    push_byte(8'hA5); push_byte(8'h57); push_byte(a); push_byte(d); push_byte(chk);
  endtask

  task automatic send_read(input logic [7:0] a, input logic [7:0] chk_xor);
    logic [7:0] chk;
    chk = 8'h52 ^ a ^ chk_xor;
    if (chk_xor != 8'h00) begin
      exp_q.push_back(8'h15);
      exp_err_cnt++;
    end else begin
      exp_rd_q.push_back(a);
      exp_q.push_back(8'h06);
      exp_q.push_back(model_mem[a]);
    end
    push_byte(8'hA5); push_byte(8'h52); push_byte(a); push_byte(chk);
  endtask

  task automatic send_badcmd(input logic [7:0] c);
    exp_q.push_back(8'h15);
    exp_err_cnt++;
    push_byte(8'hA5); push_byte(c);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || exp_wr_q.size() != 0 ||
            exp_rd_q.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq("drain_within_budget", i < budget, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_quiet_outputs();
    check_eq("rst_rd_uart", rd_uart, 0);
    check_eq("rst_wr_uart", wr_uart, 0);
    check_eq("rst_reg_wr", reg_wr, 0);
    check_eq("rst_reg_rd", reg_rd, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_w_data", w_data, 0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_wdata", reg_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int kind, t0, k;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h99;
    model_mem[8'h10] = 8'h99;

    // Reset state, with a byte waiting that must not be popped during reset.
    rx_q.push_back(8'h11);
    repeat (3) @(negedge clk);
    check_quiet_outputs();
    @(posedge clk); #3; reset = 1'b0;

    send_read(8'h10, 8'h00);           // A5 52 10 42 -> 06 99
    wait_drain(500);
    send_write(8'h10, 8'h3C, 8'h00);   // A5 57 10 3C 7B -> 06
    wait_drain(500);
    check_eq("reg_addr_held", reg_addr, 8'h10);
    check_eq("reg_wdata_held", reg_wdata, 8'h3C);
    send_write(8'h10, 8'h3C, 8'h7B);   // CHK 00 -> 15
    wait_drain(500);
    send_badcmd(8'h41);
    push_byte(8'h11); push_byte(8'h22);
    send_write(8'h20, 8'h5A, 8'h00);
    wait_drain(500);
    check_eq("frame_err_directed", err_cnt, exp_err_cnt);

    // Timeout on a stalled partial frame, then recovery.
    push_byte(8'hA5); push_byte(8'h57);
    exp_err_cnt++;
    t0 = err_cnt;
    k = 0;
    while (err_cnt == t0 && k < 4 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    check_eq("timeout_seen", err_cnt, t0 + 1);
    check_eq("timeout_latency", last_err_cyc - last_pop_cyc, TIMEOUT + 1);
    wait_drain(500);
    send_write(8'h21, 8'hC3, 8'h00);
    wait_drain(500);

    // Backpressure during a read response with another frame queued behind.
    force_full = 1'b1;
    send_read(8'h33, 8'h00);
    send_write(8'h34, 8'h77, 8'h00);
    k = 0;
    while (exp_rd_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp_read_strobe_seen", exp_rd_q.size(), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("bp_no_pop", rd_uart, 0);
      check_eq("bp_w_data", w_data, 8'h06);
    end
    force_full = 1'b0;
    wait_drain(500);

    // Reset mid-frame; the tail bytes must be discarded in IDLE.
    push_byte(8'hA5); push_byte(8'h57); push_byte(8'h10);
    k = 0;
    while (rx_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #3; reset = 1'b1;
    @(negedge clk);
    check_quiet_outputs();
    @(posedge clk); #3; reset = 1'b0;
    push_byte(8'h3C); push_byte(8'h7B);
    wait_drain(500);
    repeat (20) @(negedge clk);
    check_eq("frame_err_after_reset", err_cnt, exp_err_cnt);

    // Randomized frame mix with random TX backpressure.
    rand_bp = 1'b1;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: send_write(8'($urandom), 8'($urandom), 8'h00);
        1: send_read(8'($urandom), 8'h00);
        2: send_write(8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)));
        3: send_read(8'($urandom), 8'($urandom_range(1, 255)));
        4: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
          send_badcmd(b);
        end
        default: begin
          b = 8'($urandom);
          while (b == 8'hA5) b = 8'($urandom);
          push_byte(b);
        end
      endcase
    end
    wait_drain(5000);
    rand_bp = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("frame_err_total", err_cnt, exp_err_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
